redraw_ctrl: RTL and testbench



---
 rtl/redraw_pkg.sv | 27 ++
 rtl/redraw_ctrl_clear_engine.sv | 47 ++++
 rtl/redraw_ctrl.sv | 143 ++++++++++++++
 tb/tb_redraw_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/redraw_pkg.sv
// Shared types and screen constants for the redraw sequencer.
package redraw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned C_W      = 3;

  typedef logic [C_W-1:0] colour_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_START = 2'd1,
    ST_DRAW  = 2'd2,
    ST_IDLE  = 2'd3
  } state_t;

  // One pixel write on the VGA adapter port.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    colour_t        colour;
    logic           plot;
  } pixel_t;

endpackage

// File: rtl/redraw_ctrl_clear_engine.sv
// Background sweep counters: x inner, y outer, both wrap to 0 after the
// last pixel. i_start forces a fresh sweep from (0,0).
module clear_engine
  import redraw_pkg::*;
#(
  parameter int unsigned WIDTH  = SCREEN_W,
  parameter int unsigned HEIGHT = SCREEN_H
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_en,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last_c
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end  = (r_x == X_W'(WIDTH - 1));
  assign w_y_end  = (r_y == Y_W'(HEIGHT - 1));
  assign o_last_c = w_x_end && w_y_end;
  assign o_x      = r_x;
  assign o_y      = r_y;

  // Advance one pixel per enabled cycle, raster order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/redraw_ctrl.sv
// Redraw sequencer owning the VGA write port: background clear, drawer start,
// pixel forwarding and collapsing of moves into one follow-up redraw.
// Optional feature macro: REDRAW_CLEAR_EN (clear the background before every
// redraw, not only after reset).
module redraw_ctrl
  import redraw_pkg::*;
#(
  parameter int unsigned WIDTH     = SCREEN_W,
  parameter int unsigned HEIGHT    = SCREEN_H,
  parameter colour_t     BG_COLOUR = 3'b000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           move_valid,
  output logic           draw_start,
  input  logic           draw_done,
  input  logic [X_W-1:0] drw_x,
  input  logic [Y_W-1:0] drw_y,
  input  logic [C_W-1:0] drw_colour,
  input  logic           drw_plot,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           pending
);

`ifdef REDRAW_CLEAR_EN
  localparam state_t REDRAW_ST = ST_CLEAR;
`else
  localparam state_t REDRAW_ST = ST_START;
`endif

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_pending;
  logic           w_pending_nxt;
  pixel_t         r_pix;
  pixel_t         w_pix_nxt;
  logic           r_draw_start;
  logic           w_draw_start_nxt;
  logic           r_busy;
  logic           w_busy_nxt;
  logic           w_clr_en;
  logic           w_clr_start;
  logic [X_W-1:0] w_clr_x;
  logic [Y_W-1:0] w_clr_y;
  logic           w_clr_last;

  clear_engine #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_clear (
    .i_clk    (clk),
    .i_rst_n  (resetn),
    .i_start  (w_clr_start),
    .i_en     (w_clr_en),
    .o_x      (w_clr_x),
    .o_y      (w_clr_y),
    .o_last_c (w_clr_last)
  );

  // State, pending flag and registered VGA/drawer outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_CLEAR;
      r_pending    <= 1'b0;
      r_pix        <= '0;
      r_draw_start <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_pix        <= w_pix_nxt;
      r_draw_start <= w_draw_start_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next state, pending update and output mux.
  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending;
    w_pix_nxt        = r_pix;
    w_pix_nxt.plot   = 1'b0;
    w_draw_start_nxt = 1'b0;
    w_clr_en         = 1'b0;
    w_clr_start      = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_clr_en         = 1'b1;
        w_pix_nxt.x      = w_clr_x;
        w_pix_nxt.y      = w_clr_y;
        w_pix_nxt.colour = BG_COLOUR;
        w_pix_nxt.plot   = 1'b1;
        if (move_valid) w_pending_nxt = 1'b1;
        if (w_clr_last) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_draw_start_nxt = 1'b1;
        if (move_valid) w_pending_nxt = 1'b1;
        w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        w_pix_nxt.x      = drw_x;
        w_pix_nxt.y      = drw_y;
        w_pix_nxt.colour = drw_colour;
        w_pix_nxt.plot   = drw_plot;
        if (draw_done) begin
          if (r_pending || move_valid) begin
            w_pending_nxt = 1'b0;
            w_state_nxt   = REDRAW_ST;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (move_valid) begin
          w_pending_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (move_valid) w_state_nxt = REDRAW_ST;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase

    // Fresh sweep whenever CLEAR is entered from another state.
    w_clr_start = (w_state_nxt == ST_CLEAR) && (r_state != ST_CLEAR);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  assign x          = r_pix.x;
  assign y          = r_pix.y;
  assign colour     = r_pix.colour;
  assign plot       = r_pix.plot;
  assign draw_start = r_draw_start;
  assign busy       = r_busy;
  assign pending    = r_pending;

endmodule

// File: tb/tb_redraw_ctrl.sv
// Directed bench for redraw_ctrl: reset clear, drawer forwarding, move
// collapsing, coincident move/done and asynchronous reset behaviour.
module tb_redraw_ctrl;

  localparam int NPIX = 19200;
`ifdef REDRAW_CLEAR_EN
  localparam int EXP_CYC   = 19201;
  localparam int EXP_PLOTS = 19200;
`else
  localparam int EXP_CYC   = 1;
  localparam int EXP_PLOTS = 0;
`endif

  logic       clk;
  logic       resetn;
  logic       move_valid;
  logic       draw_start;
  logic       draw_done;
  logic [7:0] drw_x;
  logic [6:0] drw_y;
  logic [2:0] drw_colour;
  logic       drw_plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       pending;

  int total = 0;
  int bad   = 0;

  redraw_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .move_valid (move_valid),
    .draw_start (draw_start),
    .draw_done  (draw_done),
    .drw_x      (drw_x),
    .drw_y      (drw_y),
    .drw_colour (drw_colour),
    .drw_plot   (drw_plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step negedges until draw_start is seen (bounded), tallying clear writes.
  task automatic wait_start(output int cyc, output int plots, output logic busy_low,
                            output logic [7:0] lx, output logic [6:0] ly,
                            output logic [2:0] cor, output logic ds_early);
    cyc = 0; plots = 0; busy_low = 1'b0; lx = '0; ly = '0; cor = '0; ds_early = 1'b0;
    while (draw_start !== 1'b1 && cyc < 25000) begin
      if (plot === 1'b1) begin
        plots++;
        lx  = x;
        ly  = y;
        cor = cor | colour;
      end
      if (busy !== 1'b1) busy_low = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin : stim
    int         cyc, plots, starts;
    logic       busy_low, ds_early;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] cor;
    logic [18:0] exp_pix;

    resetn = 1'b0; move_valid = 1'b0; draw_done = 1'b0;
    drw_x = '0; drw_y = '0; drw_colour = '0; drw_plot = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_draw_start", 32'(draw_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);

    // Reset release: full background clear
    resetn = 1'b1;
    @(negedge clk);
    check("clr0_first", 32'({x, y, plot}), 32'({8'd0, 7'd0, 1'b1}));
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("clr0_plots", 32'(plots), 32'(NPIX));
    check("clr0_cycles", 32'(cyc), 32'(NPIX));
    check("clr0_last", 32'({lx, ly}), 32'({8'd159, 7'd119}));
    check("clr0_colour", 32'(cor), 32'd0);
    check("clr0_ds_plot", 32'(plot), 32'd0);
    check("clr0_busy", 32'(busy_low), 32'd0);

    // Drawer stream of 50 pixels, draw_done with the last one
    for (int k = 0; k < 50; k++) begin
      drw_x = 8'(k + 10); drw_y = 7'(k + 5); drw_colour = 3'(k); drw_plot = 1'b1;
      draw_done = (k == 49);
      @(negedge clk);
      exp_pix = {8'(k + 10), 7'(k + 5), 3'(k), 1'b1};
      check("fwd_pix", 32'({x, y, colour, plot}), 32'(exp_pix));
      if (k == 0) check("ds_one_cycle", 32'(draw_start), 32'd0);
    end
    check("done_busy_fall", 32'(busy), 32'd0);
    drw_plot = 1'b0; draw_done = 1'b0;
    @(negedge clk);
    check("idle_plot", 32'(plot), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pending", 32'(pending), 32'd0);

    // Drawer pixel in IDLE is dropped
    drw_plot = 1'b1; drw_x = 8'd7;
    @(negedge clk);
    check("idle_drop", 32'(plot), 32'd0);
    drw_plot = 1'b0;

    // Move in IDLE starts a redraw
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    check("mv_idle_busy", 32'(busy), 32'd1);
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("mv_idle_cyc", 32'(cyc), 32'(EXP_CYC));
    check("mv_idle_plots", 32'(plots), 32'(EXP_PLOTS));

    // Three moves during DRAW collapse into one pending redraw
    for (int i = 0; i < 3; i++) begin
      move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
    end
    check("mv3_pending", 32'(pending), 32'd1);
    check("mv3_busy", 32'(busy), 32'd1);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("mv3_pend_clr", 32'(pending), 32'd0);
    check("mv3_busy_hold", 32'(busy), 32'd1);
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("mv3_redraw_cyc", 32'(cyc), 32'(EXP_CYC));
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("mv3_idle_busy", 32'(busy), 32'd0);
    starts = 0;
    busy_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (draw_start === 1'b1) starts++;
      if (busy !== 1'b0) busy_low = 1'b1;
      @(negedge clk);
    end
    check("mv3_no_extra_start", 32'(starts), 32'd0);
    check("mv3_stays_idle", 32'(busy_low), 32'd0);

    // Move coincident with draw_done, nothing pending
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("co_first_cyc", 32'(cyc), 32'(EXP_CYC));
    check("co_pending0", 32'(pending), 32'd0);
    draw_done = 1'b1; move_valid = 1'b1;
    @(negedge clk);
    draw_done = 1'b0; move_valid = 1'b0;
    check("co_busy", 32'(busy), 32'd1);
    check("co_pending", 32'(pending), 32'd0);
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("co_redraw_cyc", 32'(cyc), 32'(EXP_CYC));
    check("co_busy_never_low", 32'(busy_low), 32'd0);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("co_end_busy", 32'(busy), 32'd0);

    // Reset asserted mid-DRAW with a request pending
    move_valid = 1'b1;
    @(negedge clk);
    drw_plot = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    wait_start(cyc, plots, busy_low, lx, ly, cor, ds_early);
    check("rs_ds_seen", 32'(draw_start), 32'd1);
    check("rs_pending_set", 32'(pending), 32'd1);
    check("rs_start_drop", 32'(plot), 32'd0);
    resetn = 1'b0;
    #1;
    check("rs_ds_async", 32'(draw_start), 32'd0);
    check("rs_pend_async", 32'(pending), 32'd0);
    check("rs_busy_async", 32'(busy), 32'd1);
    drw_plot = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rs_restart", 32'({x, y, plot}), 32'({8'd0, 7'd0, 1'b1}));
    repeat (3) @(negedge clk);
    check("rs_clr_x3", 32'({x, y, plot}), 32'({8'd3, 7'd0, 1'b1}));

    // Reset again mid-CLEAR: plot drops at once, sweep restarts at (0,0)
    resetn = 1'b0;
    #1;
    check("rc_plot_async", 32'(plot), 32'd0);
    check("rc_x_async", 32'(x), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rc_restart", 32'({x, y, plot}), 32'({8'd0, 7'd0, 1'b1}));
    @(negedge clk);
    check("rc_second", 32'({x, y, plot}), 32'({8'd1, 7'd0, 1'b1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
